// File: rtl/tagged_dispatch_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tagged_dispatch_fifo_pkg
// Brief    : Shared sizing defaults and helpers for the tagged dispatch FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef NUM_FIFOS
`define NUM_FIFOS 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef DEPTH
`define DEPTH 4
`endif

package tagged_dispatch_fifo_pkg;

    localparam int C_NUM_FIFOS = `NUM_FIFOS;
    localparam int C_WIDTH     = `WIDTH;
    localparam int C_DEPTH     = `DEPTH;

    function automatic logic is_onehot0(input logic [31:0] vec);
        return (vec & (vec - 32'd1)) == 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tagged_dispatch_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : tagged_dispatch_fifo_if
// Brief    : Push/dispatch/status bundle between a producer and the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface tagged_dispatch_fifo_if
    import tagged_dispatch_fifo_pkg::*;
#(
    parameter int NUM_FIFOS = C_NUM_FIFOS,
    parameter int WIDTH     = C_WIDTH,
    parameter int DEPTH     = C_DEPTH,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                    push;
    logic [TAGWIDTH-1:0]     push_sel;
    logic [WIDTH-1:0]        data_in;
    logic [NUM_FIFOS-1:0]    rdy;
    logic [NUM_FIFOS-1:0]    vld;
    logic [WIDTH-1:0]        data_out;
    logic                    full;
    logic                    empty;
    logic [NUM_FIFOS*CW-1:0] pending;
    logic                    tag_err;

    modport master (
        output push, push_sel, data_in, rdy,
        input  vld, data_out, full, empty, pending, tag_err
    );

    modport slave (
        input  push, push_sel, data_in, rdy,
        output vld, data_out, full, empty, pending, tag_err
    );

endinterface

`default_nettype wire

// File: rtl/circular_pointer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : circular_pointer_fifo
// Brief    : Circular buffer with wrap-bit pointers; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module circular_pointer_fifo
    import tagged_dispatch_fifo_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int DEPTH = C_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;

    // The extra MSB on each pointer separates a full buffer from an empty one.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign full    = (w_count == (AW + 1)'(DEPTH));
    assign empty   = (w_count == '0);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (rd_en && !empty)
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && !full)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/tagged_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tagged_dispatch_fifo
// Brief    : In-order shared buffer dispatching each word to its tagged port.
// Revision : 1.0 - initial release
// ============================================================================
module tagged_dispatch_fifo
    import tagged_dispatch_fifo_pkg::*;
#(
    parameter int NUM_FIFOS = `NUM_FIFOS,
    parameter int WIDTH     = `WIDTH,
    parameter int DEPTH     = `DEPTH,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input wire logic              clk,
    input wire logic              rst,
    tagged_dispatch_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + TAGWIDTH;

    logic [EW-1:0]        w_head;
    logic [TAGWIDTH-1:0]  w_head_tag;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_tag_ok;
    logic                 w_push_acc;
    logic                 w_pop;
    logic [NUM_FIFOS-1:0] w_vld;
    logic [NUM_FIFOS-1:0] w_inc;
    logic [NUM_FIFOS-1:0] w_dec;
    logic [CW-1:0]        r_pending [NUM_FIFOS];
    logic                 r_tag_err;

    circular_pointer_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push_acc),
        .wr_data ({bus.push_sel, bus.data_in}),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // With a power-of-two port count every encodable tag is legal.
    generate
        if (NUM_FIFOS == (1 << TAGWIDTH)) begin : g_tag_all
            assign w_tag_ok = 1'b1;
        end else begin : g_tag_chk
            assign w_tag_ok = (32'(bus.push_sel) < NUM_FIFOS);
        end
    endgenerate

    assign w_head_tag = w_head[EW-1 -: TAGWIDTH];
    assign w_push_acc = bus.push && !w_full && w_tag_ok;
    assign w_pop      = |(w_vld & bus.rdy);

    genvar k;
    generate
        for (k = 0; k < NUM_FIFOS; k++) begin : g_dest
            assign w_vld[k] = !w_empty && (w_head_tag == TAGWIDTH'(k));
            assign w_inc[k] = w_push_acc && (bus.push_sel == TAGWIDTH'(k));
            assign w_dec[k] = w_vld[k] && bus.rdy[k];
            assign bus.pending[k*CW +: CW] = r_pending[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '{default: '0};
            r_tag_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_pending[i] <= r_pending[i] + CW'(1);
                else if (!w_inc[i] && w_dec[i])
                    r_pending[i] <= r_pending[i] - CW'(1);
            end
            r_tag_err <= bus.push && !w_tag_ok;
        end
    end

    assign bus.vld      = w_vld;
    assign bus.data_out = w_head[WIDTH-1:0];
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.tag_err  = r_tag_err;

`ifdef FORMAL
    logic [31:0] w_sum;
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_FIFOS; i++)
            w_sum = w_sum + 32'(r_pending[i]);
        assert (is_onehot0(32'(w_vld)));
        assert (w_sum == 32'(u_store.w_count));
        assert (!(w_pop && w_empty));
    end
`endif

endmodule

`default_nettype wire
